// File: rtl/console_line_formatter_pkg.sv
// Shared types, ASCII constants and sizing helpers for the console line formatter.
package console_fmt_pkg;

  typedef enum logic [1:0] {
    MODE_RULE  = 2'd0,
    MODE_ALPHA = 2'd1,
    MODE_DEC   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_EMIT    = 2'd2,
    S_NL      = 2'd3
  } fmt_state_e;

  localparam logic [7:0] ASCII_A  = 8'h61;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_QM = 8'h3F;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  // ceil(w*log10(2)); w*log10(2) is never an integer for w>0, so the rounding is exact
  function automatic int DEC_DIGITS(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [63:0] POW26(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd26;
    return p;
  endfunction

endpackage

// File: rtl/console_line_formatter_if.sv
// Command and byte-stream bundle between a command source/byte sink and the formatter.
interface console_fmt_if #(
  parameter int LINE_LEN = 76,
  parameter int VALUE_W  = 16
);
  localparam int LW = $clog2(LINE_LEN + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_mode;
  logic [7:0]         cmd_fill;
  logic [LW-1:0]      cmd_len;
  logic [VALUE_W-1:0] cmd_value;
  logic               cmd_nl;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_char;
  logic               out_last;
  logic               overflow;

  modport master (
    output cmd_valid, cmd_mode, cmd_fill, cmd_len, cmd_value, cmd_nl, out_ready,
    input  cmd_ready, out_valid, out_char, out_last, overflow
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_fill, cmd_len, cmd_value, cmd_nl, out_ready,
    output cmd_ready, out_valid, out_char, out_last, overflow
  );
endinterface

// File: rtl/console_line_formatter_serializer.sv
// Iterative radix conversion: one digit per cycle into an LSB-first buffer, read back MSB-first.
module radix_digit_serializer #(
  parameter  int VALUE_W = 16,
  parameter  int DEPTH   = 5,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [4:0]         radix_i,
  input  logic [CW-1:0]      fixed_count_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               done_o,
  output logic [CW-1:0]      ndig_o,
  input  logic [CW-1:0]      idx_i,
  output logic [4:0]         digit_o
);

  logic                  busy_q;
  logic [VALUE_W-1:0]    val_q, quot;
  logic [4:0]            radix_q, rem;
  logic [CW-1:0]         fixed_q, cnt_q, sel;
  logic [DEPTH-1:0][4:0] dig_q;
  logic                  last;

  // Constant divisors keep the divider to two fixed-ratio circuits.
  always_comb begin
    quot = (radix_q == 5'd26) ? val_q / VALUE_W'(26) : val_q / VALUE_W'(10);
    rem  = 5'(val_q - quot * VALUE_W'(radix_q));
    if (fixed_q != '0) last = (cnt_q == fixed_q - CW'(1));
    else               last = (quot == '0) || (cnt_q == CW'(DEPTH - 1));
    sel = cnt_q - CW'(1) - idx_i;
  end

  assign done_o  = busy_q && last;
  assign ndig_o  = cnt_q;
  assign digit_o = (sel < CW'(DEPTH)) ? dig_q[sel] : 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      val_q   <= '0;
      radix_q <= '0;
      fixed_q <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      val_q   <= value_i;
      radix_q <= radix_i;
      fixed_q <= fixed_count_i;
      cnt_q   <= '0;
    end else if (busy_q) begin
      dig_q[cnt_q] <= rem;
      val_q        <= quot;
      cnt_q        <= cnt_q + CW'(1);
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/console_line_formatter.sv
// Turns RULE / ALPHA / DEC commands into a backpressured ASCII byte line.
module console_line_formatter
  import console_fmt_pkg::*;
#(
  parameter int LINE_LEN     = 76,
  parameter int VALUE_W      = 16,
  parameter int ALPHA_DIGITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  console_fmt_if.slave  bus
);

  localparam int LW    = $clog2(LINE_LEN + 1);
  localparam int DEPTH = (ALPHA_DIGITS > DEC_DIGITS(VALUE_W)) ? ALPHA_DIGITS : DEC_DIGITS(VALUE_W);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = (LW > CW) ? LW : CW;
  localparam logic [63:0] ALPHA_LIM = POW26(ALPHA_DIGITS);

  fmt_state_e         state_q, state_d;
  mode_e              mode_q, cmd_mode;
  logic [7:0]         fill_q;
  logic [IW-1:0]      rlen_q, rlen_d, idx_q, idx_d, body_len;
  logic [VALUE_W-1:0] val_q;
  logic               nl_q;
  logic               accept, xfer, last_body, alpha_ovf, ser_start, ser_done;
  logic [CW-1:0]      ser_ndig;
  logic [4:0]         ser_digit;

  // Reserved mode decodes as RULE; out-of-range lengths clamp to a full line.
  always_comb begin
    case (bus.cmd_mode)
      2'd1:    cmd_mode = MODE_ALPHA;
      2'd2:    cmd_mode = MODE_DEC;
      default: cmd_mode = MODE_RULE;
    endcase
    if (bus.cmd_len == '0 || int'(bus.cmd_len) > LINE_LEN) rlen_d = IW'(LINE_LEN);
    else                                                    rlen_d = IW'(bus.cmd_len);
  end

  assign accept    = bus.cmd_valid && (state_q == S_IDLE);
  assign xfer      = bus.out_valid && bus.out_ready;
  assign body_len  = (mode_q == MODE_RULE) ? rlen_q : IW'(ser_ndig);
  assign last_body = (idx_q == body_len - IW'(1));
  assign alpha_ovf = (mode_q == MODE_ALPHA) && (64'(val_q) >= ALPHA_LIM);

  radix_digit_serializer #(.VALUE_W(VALUE_W), .DEPTH(DEPTH)) u_ser (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (ser_start),
    .radix_i       ((cmd_mode == MODE_ALPHA) ? 5'd26 : 5'd10),
    .fixed_count_i ((cmd_mode == MODE_ALPHA) ? CW'(ALPHA_DIGITS) : CW'(0)),
    .value_i       (bus.cmd_value),
    .done_o        (ser_done),
    .ndig_o        (ser_ndig),
    .idx_i         (CW'(idx_q)),
    .digit_o       (ser_digit)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ser_start = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        idx_d     = '0;
        ser_start = (cmd_mode != MODE_RULE);
        state_d   = (cmd_mode == MODE_RULE) ? S_EMIT : S_CONVERT;
      end
      S_CONVERT: if (ser_done) state_d = S_EMIT;
      S_EMIT: if (xfer) begin
        if (last_body) begin
          idx_d   = '0;
          state_d = nl_q ? S_NL : S_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_NL: if (xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so they hold while the sink stalls.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_char  = 8'h00;
    case (state_q)
      S_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_body && !nl_q;
        case (mode_q)
          MODE_ALPHA: bus.out_char = alpha_ovf ? ASCII_QM : ASCII_A + {3'b000, ser_digit};
          MODE_DEC:   bus.out_char = ASCII_0 + {3'b000, ser_digit};
          default:    bus.out_char = fill_q;
        endcase
      end
      S_NL: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_char  = ASCII_NL;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.overflow  = (state_q == S_CONVERT) && alpha_ovf && (ser_ndig == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mode_q  <= MODE_RULE;
      fill_q  <= '0;
      rlen_q  <= '0;
      val_q   <= '0;
      nl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        mode_q <= cmd_mode;
        fill_q <= bus.cmd_fill;
        rlen_q <= rlen_d;
        val_q  <= bus.cmd_value;
        nl_q   <= bus.cmd_nl;
      end
    end
  end

endmodule

// File: doc/console_line_formatter.md
Name: console_line_formatter

Overview:
- Hardware text-line generator for on-chip debug and trace output.
- Accepts one command per transaction: a horizontal rule, an alphabetic index, or a decimal value. Streams the resulting ASCII bytes over a valid/ready byte interface, typically into a UART or trace FIFO.
- Generalises the rule and alpha-index printing helpers: rule length and alpha digit count are configurable, a decimal mode is added, and the output is backpressured.

Parameters:
- LINE_LEN, 76: maximum and default rule length in characters.
- VALUE_W, 16: width of the numeric input.
- ALPHA_DIGITS, 2: fixed number of base-26 characters emitted in alpha mode.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  formatter can accept a command.
- cmd_mode  in  2  0=RULE, 1=ALPHA, 2=DEC, 3=reserved (treated as RULE).
- cmd_fill  in  8  RULE fill character.
- cmd_len  in  $clog2(LINE_LEN+1)  RULE length; 0 means LINE_LEN.
- cmd_value  in  VALUE_W  ALPHA/DEC operand.
- cmd_nl  in  1  append '\n' (0x0A) after the body.
- out_valid  out  1  out_char valid.
- out_ready  in  1  sink accepts the byte.
- out_char  out  8  ASCII byte.
- out_last  out  1  marks the final byte of the line.
- overflow  out  1  one-cycle pulse when an ALPHA value is out of range.

Behaviour:
- Reset (async, any time, including mid-line):
  - state=IDLE, out_valid=0, out_char=0, out_last=0, overflow=0, cmd_ready=1, all counters cleared.
  - A partially emitted line is abandoned; no completion is signalled.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields. Go to EMIT for RULE, or CONVERT for ALPHA/DEC.
  - CONVERT: cmd_ready=0. Produces one digit per cycle (value mod radix, value /= radix) into an LSB-first buffer.
    - ALPHA: radix 26, exactly ALPHA_DIGITS cycles.
    - DEC: radix 10, runs until the quotient is 0, minimum 1 digit, at most DEC_DIGITS(VALUE_W) cycles.
    - Then go to EMIT.
  - EMIT: outputs the body MSB-first.
    - RULE: cmd_fill repeated L times, where L = (cmd_len==0 || cmd_len>LINE_LEN) ? LINE_LEN : cmd_len.
    - ALPHA: 'a'+digit.
    - DEC: '0'+digit.
    - On the last body byte, go to NL if cmd_nl, else IDLE.
  - NL: outputs 0x0A, then IDLE.
- ALPHA range:
  - Values >= 26^ALPHA_DIGITS emit '?' ALPHA_DIGITS times.
  - overflow pulses for one cycle on the first CONVERT cycle.
  - Values in range are zero-padded, so 0 gives "aa".
- DEC: no leading zeros; 0 gives "0".
- Handshake:
  - A byte transfers when out_valid&&out_ready.
  - While out_valid && !out_ready, out_char and out_last hold stable and out_valid stays 1.
  - The next byte is presented in the cycle after a transfer, so one byte per cycle is sustained under out_ready=1.
- out_last=1 only on the final byte: the '\n' if cmd_nl, else the last body byte.
- Latency from accept to first out_valid:
  - RULE: 1 cycle.
  - ALPHA: ALPHA_DIGITS+1 cycles.
  - DEC: (digit count)+1 cycles.
- cmd_ready returns to 1 in the cycle after the last byte transfers.
- A new command can be accepted in that cycle; the cmd_valid of a back-to-back command is honoured then.

Decomposition:
- Shared package console_fmt_pkg holds:
  - mode enum (RULE, ALPHA, DEC).
  - ASCII constants: 'a', '0', '?', 0x0A.
  - constant function DEC_DIGITS(w), equal to ceil(w*log10(2)).
  - constant function POW26(n).
- Digit buffer depth is max(ALPHA_DIGITS, DEC_DIGITS(VALUE_W)).
- One sub-module: radix_digit_serializer. It owns the CONVERT iteration and buffer, with start, radix, fixed_count and done signals, and exposes digits MSB-first by index.

Test Plan:
- RULE, cmd_fill='*', cmd_len=0, cmd_nl=1, out_ready=1 -> 76 bytes 0x2A then 0x0A; out_last only on 0x0A; 77 transfers in 77 consecutive cycles.
- ALPHA (ALPHA_DIGITS=2), values 0, 27, 675 with cmd_nl=0 -> "aa", "bb", "zz"; out_last on the 2nd byte; overflow stays 0.
- ALPHA, value 676 -> "??"; overflow pulses exactly once.
- DEC, VALUE_W=16: 0 -> "0"; 40960 -> "40960"; 65535 -> "65535"; first byte is valid 6 cycles after accept for 65535.
- Backpressure: RULE with cmd_len=5, out_ready toggled with a random pattern -> exactly 5 fill bytes plus '\n'; out_char/out_last stable whenever valid && !ready; cmd_ready=0 throughout.
- Reset mid-line: assert rst_n=0 after the 3rd byte of a 76-char rule -> out_valid=0 immediately, cmd_ready=1 after release; next ALPHA 27 command yields "bb" with no leftover bytes.
